shift_sub_divider: RTL
======================

SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

Interface
REQ-001 The block SHALL have parameter DW, default 12, dividend/quotient width.
REQ-002 The block SHALL have parameter VW, default 6, divisor/remainder width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 sw  input  1  mode; 1 = two's-complement signed, 0 = unsigned; captured with start.
REQ-007 dividend  input  DW  numerator; captured with start.
REQ-008 divisor  input  VW  denominator; captured with start.
REQ-009 quotient  output  DW  registered result.
REQ-010 remainder  output  VW  registered result.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse when quotient/remainder/flags are valid.
REQ-013 div_zero  output  1  divisor was zero; valid with done.
REQ-014 ovf  output  1  signed result not representable; valid with done.

Function
REQ-015 The block SHALL use a state machine with states IDLE, CALC, FIX.
- IDLE -> CALC: start=1 and divisor!=0.
- IDLE -> FIX: start=1 and divisor=0.
- CALC -> FIX: after DW iterations.
- FIX -> IDLE: always.
REQ-016 At the accepting edge (cycle 0), the block SHALL capture sw, dividend and divisor, and set busy=1.
REQ-017 In signed mode, the block SHALL convert operands to magnitudes at capture and record both signs.
REQ-018 CALC SHALL perform restoring shift-subtract division, one quotient bit per cycle, MSB first.
- Partial remainder width: VW+1 bits.
- Exactly DW cycles (edges 1..DW).
REQ-019 At edge DW+1 (FIX), the block SHALL:
- Register quotient and remainder.
- Pulse done=1 for exactly one cycle.
- Clear busy.
- Return to IDLE.
Total latency: start edge to done edge = DW+1 cycles (13 at default).
REQ-020 Signed sign fix SHALL be applied in FIX.
- Quotient negated if the operand signs differ.
- Remainder takes the dividend's sign.
- Truncation toward zero; dividend = quotient*divisor + remainder.
REQ-021 Signed overflow: dividend = most negative value and divisor = -1 SHALL give ovf=1, quotient = most negative value, remainder = 0.
REQ-022 ovf SHALL be 0 in unsigned mode.
REQ-023 Divisor=0 SHALL give div_zero=1, quotient = all ones, remainder = 0, with done at edge 1.
REQ-024 start while busy=1 SHALL be ignored; the operands in flight SHALL be unaffected.
REQ-025 quotient, remainder, div_zero and ovf SHALL hold their values until the next FIX.
REQ-026 start asserted in the same cycle as done (FIX) SHALL be ignored; the next operation is accepted from IDLE.

Reset
REQ-027 reset=1 SHALL immediately force:
- state = IDLE
- quotient = 0, remainder = 0
- busy = 0, done = 0, div_zero = 0, ovf = 0
- all internal operand/iteration registers = 0
REQ-028 Reset mid-operation SHALL abort the operation with no done pulse; the next start after reset deassertion SHALL be processed normally.

Structure
REQ-029 Package mul_div_pkg SHALL hold:
- default DW/VW constants;
- state encoding constants IDLE=2'd0, CALC=2'd1, FIX=2'd2;
- the iteration counter width constant.
REQ-030 Magnitude/sign restoration SHALL be a combinational sub-module div_sign_fix, instantiated once for the FIX outputs.
REQ-031 Iteration count SHALL be a down-counter loaded with DW at acceptance.

Verification
REQ-032 Unsigned: sw=0, dividend=12'd4095, divisor=6'd63 -> 13 cycles later done=1, quotient=12'd65, remainder=6'd0.
REQ-033 Signed: sw=1, dividend=-100 (12'hF9C), divisor=7 -> quotient=12'hFF2 (-14), remainder=6'h3E (-2), ovf=0.
REQ-034 Signed overflow: sw=1, dividend=12'h800, divisor=6'h3F -> quotient=12'h800, remainder=0, ovf=1.
REQ-035 Divide by zero: dividend=12'd100, divisor=0 -> done at next edge, div_zero=1, quotient=12'hFFF, remainder=0.
REQ-036 Busy/abort:
- Second start with dividend=12'd10 at cycle 5 -> ignored; first result unchanged.
- Reset at cycle 7 -> no done, all outputs 0.
- Fresh start after reset -> correct result 13 cycles later.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared constants and state encoding for the
// shift/subtract divider.
package mul_div_pkg;

  localparam int DW_DEF = 12;
  localparam int VW_DEF = 6;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Restores signs on the unsigned quotient/remainder
// and flags divide-by-zero and signed overflow results.
module div_sign_fix
  import mul_div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          signed_i,
  input  logic          neg_a_i,
  input  logic          neg_b_i,
  input  logic          zero_i,
  input  logic [DW-1:0] q_mag_i,
  input  logic [VW-1:0] r_mag_i,
  output logic [DW-1:0] q_o,
  output logic [VW-1:0] r_o,
  output logic          ovf_o
);

  logic diff_sign;

  assign diff_sign = neg_a_i ^ neg_b_i;

  always_comb begin
    q_o   = q_mag_i;
    r_o   = r_mag_i;
    ovf_o = 1'b0;
    if (zero_i) begin
      q_o = '1;
      r_o = '0;
    end else if (signed_i) begin
      if (diff_sign) q_o = -q_mag_i;
      if (neg_a_i)   r_o = -r_mag_i;
      // a positive magnitude with the MSB set cannot be represented
      ovf_o = ~diff_sign & q_mag_i[DW-1];
    end
  end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: one quotient bit per
// cycle, signed or unsigned operands.
module shift_sub_divider
  import mul_div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          sw,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          div_zero,
  output logic          ovf
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DW);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e state_q, state_d;

  logic             sw_q, sw_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [VW-1:0]    bmag_q, bmag_d;
  logic [DW-1:0]    wq_q, wq_d;
  logic [VW-1:0]    pr_q, pr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    quo_q, quo_d;
  logic [VW-1:0]    rem_q, rem_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;

  logic [VW:0]      trial;
  logic [VW:0]      bext;
  logic             ge;
  logic             bzero;
  logic [DW-1:0]    fix_q;
  logic [VW-1:0]    fix_r;
  logic             fix_ovf;

  // wq_q holds the dividend shifting out and quotient bits shifting in
  assign trial = {pr_q, wq_q[DW-1]};
  assign bext  = {1'b0, bmag_q};
  assign ge    = (trial >= bext);
  assign bzero = (bmag_q == '0);

  div_sign_fix #(
    .DW (DW),
    .VW (VW)
  ) u_fix (
    .signed_i (sw_q),
    .neg_a_i  (sa_q),
    .neg_b_i  (sb_q),
    .zero_i   (bzero),
    .q_mag_i  (wq_q),
    .r_mag_i  (pr_q),
    .q_o      (fix_q),
    .r_o      (fix_r),
    .ovf_o    (fix_ovf)
  );

  always_comb begin
    state_d = state_q;
    sw_d    = sw_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bmag_d  = bmag_q;
    wq_d    = wq_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // the cycle showing done also refuses a new request
        if (start && !done_q) begin
          sw_d    = sw;
          sa_d    = sw & dividend[DW-1];
          sb_d    = sw & divisor[VW-1];
          wq_d    = sa_d ? -dividend : dividend;
          bmag_d  = sb_d ? -divisor : divisor;
          pr_d    = '0;
          cnt_d   = CNT_LOAD;
          state_d = (divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        wq_d  = {wq_q[DW-2:0], ge};
        pr_d  = VW'(ge ? trial - bext : trial);
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = FIX;
      end
      FIX: begin
        quo_d   = fix_q;
        rem_d   = fix_r;
        dz_d    = bzero;
        ovf_d   = fix_ovf;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sw_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bmag_q  <= '0;
      wq_q    <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sw_q    <= sw_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bmag_q  <= bmag_d;
      wq_q    <= wq_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign div_zero  = dz_q;
  assign ovf       = ovf_q;

endmodule
